// File: rtl/hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: decode/EX/MEM/WB info in,
// forwarding selects, stall/flush and mult/div status out.
interface hazard_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_branch;
  logic       id_branch_taken;
  logic       id_md_use;
  logic [4:0] ex_rs;
  logic [4:0] ex_rt;
  logic [4:0] ex_rd;
  logic       ex_reg_write;
  logic       ex_mem_to_reg;
  logic       ex_md_start;
  logic [4:0] mem_rd;
  logic       mem_reg_write;
  logic       mem_mem_to_reg;
  logic [4:0] wb_rd;
  logic       wb_reg_write;
  logic [1:0] forward_a;
  logic [1:0] forward_b;
  logic       stall_f;
  logic       stall_d;
  logic       flush_d;
  logic       flush_e;
  logic       md_busy;
  logic       md_done;
  logic       md_overrun;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  modport master (
    output id_rs, id_rt, id_branch, id_branch_taken, id_md_use,
    output ex_rs, ex_rt, ex_rd, ex_reg_write, ex_mem_to_reg,
    output ex_md_start,
    output mem_rd, mem_reg_write, mem_mem_to_reg,
    output wb_rd, wb_reg_write,
    input  forward_a, forward_b,
    input  stall_f, stall_d, flush_d, flush_e,
    input  md_busy, md_done, md_overrun
`ifdef HAZARD_PERF_EN
    , input stall_cycles, flush_count
`endif
  );

  modport slave (
    input  id_rs, id_rt, id_branch, id_branch_taken, id_md_use,
    input  ex_rs, ex_rt, ex_rd, ex_reg_write, ex_mem_to_reg,
    input  ex_md_start,
    input  mem_rd, mem_reg_write, mem_mem_to_reg,
    input  wb_rd, wb_reg_write,
    output forward_a, forward_b,
    output stall_f, stall_d, flush_d, flush_e,
    output md_busy, md_done, md_overrun
`ifdef HAZARD_PERF_EN
    , output stall_cycles, flush_count
`endif
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller: forwarding, load-use/branch/mult-div stalls, flushes.
// Define HAZARD_PERF_EN to add saturating stall/flush counters.
module hazard_ctrl #(
  parameter int MD_LATENCY = 4
) (
  input logic         clk,
  input logic         rst_n,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  md_state_t  state;
  md_state_t  state_nx;
  logic [3:0] count;
  logic       overrun;
  logic       lw_stall;
  logic       br_stall;
  logic       md_stall;
  logic       stall;
  logic       flush;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] m_rd,
    input logic       m_w,
    input logic [4:0] w_rd,
    input logic       w_w
  );
    if (m_w && m_rd != 5'd0 && m_rd == src)
      return 2'b10;
    else if (w_w && w_rd != 5'd0 && w_rd == src)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  function automatic logic hit(
    input logic [4:0] rd,
    input logic [4:0] a,
    input logic [4:0] b
  );
    return rd != 5'd0 && (rd == a || rd == b);
  endfunction

  always_comb begin
    hz.forward_a = fwd_sel(hz.ex_rs, hz.mem_rd, hz.mem_reg_write,
                           hz.wb_rd, hz.wb_reg_write);
    hz.forward_b = fwd_sel(hz.ex_rt, hz.mem_rd, hz.mem_reg_write,
                           hz.wb_rd, hz.wb_reg_write);
  end

  assign lw_stall = hz.ex_mem_to_reg && hz.ex_reg_write &&
                    hit(hz.ex_rd, hz.id_rs, hz.id_rt);
  assign br_stall = hz.id_branch &&
                    ((hz.ex_reg_write &&
                      hit(hz.ex_rd, hz.id_rs, hz.id_rt)) ||
                     (hz.mem_mem_to_reg &&
                      hit(hz.mem_rd, hz.id_rs, hz.id_rt)));
  assign md_stall = hz.id_md_use &&
                    (state == BUSY || hz.ex_md_start);
  assign stall    = lw_stall | br_stall | md_stall;
  // A stalled branch re-resolves next cycle, so it must not flush yet.
  assign flush    = hz.id_branch_taken && !stall;

  assign hz.stall_f    = stall;
  assign hz.stall_d    = stall;
  assign hz.flush_e    = stall;
  assign hz.flush_d    = flush;
  assign hz.md_overrun = overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (hz.ex_md_start) state_nx = BUSY;
      BUSY:    if (count == 4'd1) state_nx = DONE;
      DONE:    state_nx = hz.ex_md_start ? BUSY : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    hz.md_busy = 1'b0;
    hz.md_done = 1'b0;
    unique case (state)
      BUSY:    hz.md_busy = 1'b1;
      DONE:    hz.md_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= 4'd0;
      overrun <= 1'b0;
    end else begin
      if (state != BUSY && hz.ex_md_start)
        count <= 4'(MD_LATENCY - 1);
      else if (state == BUSY)
        count <= count - 4'd1;
      if (state == BUSY && hz.ex_md_start)
        overrun <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (stall && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
      if (flush && flush_cnt != 32'hFFFF_FFFF)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign hz.stall_cycles = stall_cnt;
  assign hz.flush_count  = flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table for the combinational
// paths, hand sequences for the mult/div sequencer and counters.
module tb_hazard_ctrl;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  hazard_ctrl_if hz();

  hazard_ctrl #(.MD_LATENCY(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int id_rs; int id_rt; int br; int tk; int mdu;
    int ex_rs; int ex_rt; int ex_rd; int ex_rw; int ex_lw;
    int mem_rd; int mem_rw; int mem_lw;
    int wb_rd; int wb_rw;
    int fa; int fb; int st; int fd;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    hz.id_rs           = 5'(v.id_rs);
    hz.id_rt           = 5'(v.id_rt);
    hz.id_branch       = v.br[0];
    hz.id_branch_taken = v.tk[0];
    hz.id_md_use       = v.mdu[0];
    hz.ex_rs           = 5'(v.ex_rs);
    hz.ex_rt           = 5'(v.ex_rt);
    hz.ex_rd           = 5'(v.ex_rd);
    hz.ex_reg_write    = v.ex_rw[0];
    hz.ex_mem_to_reg   = v.ex_lw[0];
    hz.ex_md_start     = 1'b0;
    hz.mem_rd          = 5'(v.mem_rd);
    hz.mem_reg_write   = v.mem_rw[0];
    hz.mem_mem_to_reg  = v.mem_lw[0];
    hz.wb_rd           = 5'(v.wb_rd);
    hz.wb_reg_write    = v.wb_rw[0];
  endtask

  initial begin
    vec_t z;
    total = 0;
    bad   = 0;
    z = '{0,0,0,0,0, 0,0,0,0,0, 0,0,0, 0,0, 0,0,0,0};
    vt[0]  = z;
    vt[1]  = '{0,0,0,0,0, 5,0,0,0,0, 5,1,0, 5,1, 2,0,0,0};
    vt[2]  = '{0,0,0,0,0, 5,0,0,0,0, 5,0,0, 5,1, 1,0,0,0};
    vt[3]  = '{0,0,0,0,0, 5,0,0,0,0, 0,1,0, 0,1, 0,0,0,0};
    vt[4]  = '{0,0,0,0,0, 9,7,0,0,0, 7,1,0, 9,1, 1,2,0,0};
    vt[5]  = '{0,0,0,0,0, 0,0,0,0,0, 0,1,0, 0,1, 0,0,0,0};
    vt[6]  = '{0,8,0,0,0, 0,0,8,1,1, 0,0,0, 0,0, 0,0,1,0};
    vt[7]  = '{0,0,0,0,0, 0,0,0,1,1, 0,0,0, 0,0, 0,0,0,0};
    vt[8]  = '{0,8,0,0,0, 0,0,8,0,1, 0,0,0, 0,0, 0,0,0,0};
    vt[9]  = '{3,0,1,1,0, 0,0,0,0,0, 3,0,1, 0,0, 0,0,1,0};
    vt[10] = '{3,0,1,1,0, 0,0,0,0,0, 3,0,0, 0,0, 0,0,0,1};
    vt[11] = '{0,4,1,1,0, 0,0,4,1,0, 0,0,0, 0,0, 0,0,1,0};
    vt[12] = '{0,4,0,0,0, 0,0,4,1,0, 0,0,0, 0,0, 0,0,0,0};
    vt[13] = '{6,0,0,1,0, 0,0,6,1,1, 0,0,0, 0,0, 0,0,1,0};
    vt[14] = '{5,2,1,0,0, 0,0,0,0,0, 3,0,1, 0,0, 0,0,0,0};
    vt[15] = '{0,0,0,0,1, 0,0,0,0,0, 0,0,0, 0,0, 0,0,0,0};

    rst_n = 1'b0;
    apply(z);
    #2;
    chk("rst_busy", int'(hz.md_busy), 0);
    chk("rst_done", int'(hz.md_done), 0);
    chk("rst_ovr", int'(hz.md_overrun), 0);
    chk("rst_stall", int'(hz.stall_f), 0);
    chk("rst_fwd_a", int'(hz.forward_a), 0);
`ifdef HAZARD_PERF_EN
    chk("rst_scyc", int'(hz.stall_cycles), 0);
    chk("rst_fcnt", int'(hz.flush_count), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      apply(vt[i]);
      #1;
      chk($sformatf("v%0d_fa", i), int'(hz.forward_a), vt[i].fa);
      chk($sformatf("v%0d_fb", i), int'(hz.forward_b), vt[i].fb);
      chk($sformatf("v%0d_sf", i), int'(hz.stall_f), vt[i].st);
      chk($sformatf("v%0d_sd", i), int'(hz.stall_d), vt[i].st);
      chk($sformatf("v%0d_fe", i), int'(hz.flush_e), vt[i].st);
      chk($sformatf("v%0d_fd", i), int'(hz.flush_d), vt[i].fd);
    end

    // single mult/div issue with a dependent instruction waiting in ID
    @(negedge clk);
    apply(z);
    hz.ex_md_start = 1'b1;
    #1;
    chk("md0_busy", int'(hz.md_busy), 0);
    hz.id_md_use = 1'b1;
    #1;
    chk("md0_stall", int'(hz.stall_f), 1);
    hz.id_md_use = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      hz.ex_md_start = 1'b0;
      hz.id_md_use   = 1'b1;
      #1;
      chk($sformatf("md1_busy_c%0d", c), int'(hz.md_busy), int'(c <= 3));
      chk($sformatf("md1_done_c%0d", c), int'(hz.md_done), int'(c == 4));
      chk($sformatf("md1_stall_c%0d", c), int'(hz.stall_f), int'(c <= 3));
      chk($sformatf("md1_ovr_c%0d", c), int'(hz.md_overrun), 0);
    end

    // second issue while busy: flagged, timing unaffected
    @(negedge clk);
    apply(z);
    hz.ex_md_start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      hz.ex_md_start = (c == 2);
      #1;
      chk($sformatf("md2_busy_c%0d", c), int'(hz.md_busy), int'(c <= 3));
      chk($sformatf("md2_done_c%0d", c), int'(hz.md_done), int'(c == 4));
      chk($sformatf("md2_ovr_c%0d", c), int'(hz.md_overrun), int'(c >= 3));
    end

    // issue during DONE reloads straight into BUSY
    @(negedge clk);
    hz.ex_md_start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      hz.ex_md_start = (c == 4);
      #1;
      chk($sformatf("md3_busy_c%0d", c), int'(hz.md_busy),
          int'(c <= 3 || (c >= 5 && c <= 7)));
      chk($sformatf("md3_done_c%0d", c), int'(hz.md_done),
          int'(c == 4 || c == 8));
    end
    chk("md3_ovr_sticky", int'(hz.md_overrun), 1);

    // reset in the middle of BUSY
    @(negedge clk);
    hz.ex_md_start = 1'b1;
    @(negedge clk);
    hz.ex_md_start = 1'b0;
    #1;
    chk("md4_busy_c1", int'(hz.md_busy), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("md4_rst_busy", int'(hz.md_busy), 0);
    chk("md4_rst_ovr", int'(hz.md_overrun), 0);
    chk("md4_rst_done", int'(hz.md_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("md4_done_c%0d", c), int'(hz.md_done), 0);
      chk($sformatf("md4_busy_c%0d", c), int'(hz.md_busy), 0);
    end

`ifdef HAZARD_PERF_EN
    @(negedge clk);
    apply(z);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    chk("perf_clr_s", int'(hz.stall_cycles), 0);
    chk("perf_clr_f", int'(hz.flush_count), 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 3) begin
        apply(vt[6]);
      end else begin
        apply(z);
        hz.id_branch_taken = 1'b1;
      end
    end
    @(negedge clk);
    apply(z);
    #1;
    chk("perf_stall", int'(hz.stall_cycles), 3);
    chk("perf_flush", int'(hz.flush_count), 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
